// File: rtl/spi_slave_xcvr_if.sv
// Bus bundle for spi_slave_xcvr: SPI pins plus the local TX/RX word handshake.
// The slave modport is the transceiver's view; the master modport is the pins/host side.
interface spi_slave_xcvr_if #(
    parameter int DATA_W = 8
);
    logic              SCLK;
    logic              SS;
    logic              MOSI;
    logic              MISO;
    logic              MISO_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_abort;
    logic              tx_underrun;
    logic              busy;

    modport slave (
        input  SCLK, SS, MOSI, tx_data, tx_valid,
        output MISO, MISO_oe, tx_ready, rx_data, rx_valid, rx_abort, tx_underrun, busy
    );

    modport master (
        output SCLK, SS, MOSI, tx_data, tx_valid,
        input  MISO, MISO_oe, tx_ready, rx_data, rx_valid, rx_abort, tx_underrun, busy
    );
endinterface

// File: rtl/spi_slave_xcvr.sv
// Full-duplex SPI mode-0 slave oversampled on clk, with a one-word TX holding buffer.
// Define SPI_SLAVE_LSB_FIRST_EN for LSB-first shifting; the default build is MSB-first.
module spi_slave_xcvr #(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] IDLE_WORD = 8'hFF
) (
    input logic             clk,
    input logic             rst,
    spi_slave_xcvr_if.slave bus
);
    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic              sclk_s1, sclk_s2, sclk_prev;
    logic              ss_s1, ss_s2, ss_prev;
    logic              mosi_s1, mosi_s2;
    logic [0:0]        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] buf_word;
    logic              buf_full;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_abort;
    logic              tx_underrun;

    logic              sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic              load_now;
    logic [DATA_W-1:0] load_word;
    logic              load_bit;
    logic [DATA_W-1:0] tx_next;
    logic              next_bit;
    logic [DATA_W-1:0] rx_next;

    // SS/SCLK chains reset low, so a pin already low at reset release never looks like a start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_prev <= 1'b0;
            ss_s1     <= 1'b0;
            ss_s2     <= 1'b0;
            ss_prev   <= 1'b0;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
        end else begin
            sclk_s1   <= bus.SCLK;
            sclk_s2   <= sclk_s1;
            sclk_prev <= sclk_s2;
            ss_s1     <= bus.SS;
            ss_s2     <= ss_s1;
            ss_prev   <= ss_s2;
            mosi_s1   <= bus.MOSI;
            mosi_s2   <= mosi_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_prev;
    assign sclk_fall = ~sclk_s2 & sclk_prev;
    assign ss_rise   = ss_s2 & ~ss_prev;
    assign ss_fall   = ~ss_s2 & ss_prev;

    assign load_now = (state == IDLE) ? ss_fall
                                      : (!ss_rise && !sclk_rise && sclk_fall && bit_cnt == '0);

    always_comb begin
        load_word = IDLE_WORD;
        if (buf_full) begin
            load_word = buf_word;
        end else if (bus.tx_valid) begin
            load_word = bus.tx_data;
        end
    end

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign load_bit = load_word[0];
    assign tx_next  = tx_shift >> 1;
    assign next_bit = tx_shift[1];
    assign rx_next  = {mosi_s2, rx_shift[DATA_W-1:1]};
`else
    assign load_bit = load_word[DATA_W-1];
    assign tx_next  = tx_shift << 1;
    assign next_bit = tx_shift[DATA_W-2];
    assign rx_next  = {rx_shift[DATA_W-2:0], mosi_s2};
`endif

    // A word offered during a load cycle bypasses the buffer instead of being captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_full <= 1'b0;
            buf_word <= '0;
        end else if (load_now && buf_full) begin
            buf_full <= 1'b0;
        end else if (bus.tx_valid && !buf_full && !load_now) begin
            buf_full <= 1'b1;
            buf_word <= bus.tx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_abort    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            rx_abort    <= 1'b0;
            tx_underrun <= load_now && !buf_full && !bus.tx_valid;
            case (state)
                IDLE: begin
                    miso_oe <= 1'b0;
                    bit_cnt <= '0;
                    if (ss_fall) begin
                        tx_shift <= load_word;
                        miso     <= load_bit;
                        miso_oe  <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        rx_abort <= (bit_cnt != '0);
                        rx_shift <= '0;
                        miso_oe  <= 1'b0;
                        bit_cnt  <= '0;
                        state    <= IDLE;
                    end else if (sclk_rise) begin
                        rx_shift <= rx_next;
                        if (bit_cnt == LAST_BIT) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                            bit_cnt  <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt == '0) begin
                            tx_shift <= load_word;
                            miso     <= load_bit;
                        end else begin
                            tx_shift <= tx_next;
                            miso     <= next_bit;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.MISO        = miso;
    assign bus.MISO_oe     = miso_oe;
    assign bus.tx_ready    = !buf_full;
    assign bus.rx_data     = rx_data;
    assign bus.rx_valid    = rx_valid;
    assign bus.rx_abort    = rx_abort;
    assign bus.tx_underrun = tx_underrun;
    assign bus.busy        = (state == SHIFT);
endmodule

// File: tb/tb_spi_slave_xcvr.sv
// Self-checking bench for spi_slave_xcvr (default MSB-first build) acting as a mode-0 SPI master.
// A word-level model predicts MISO words, received words and pulse counts.
module tb_spi_slave_xcvr;
    localparam int         DATA_W    = 8;
    localparam logic [7:0] IDLE_WORD = 8'hFF;

    logic clk = 1'b0;
    logic rst;

    spi_slave_xcvr_if #(.DATA_W(DATA_W)) bus_if ();

    spi_slave_xcvr #(.DATA_W(DATA_W), .IDLE_WORD(IDLE_WORD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [7:0] exp_rx[$];
    int         exp_underrun = 0;
    int         exp_abort = 0;
    int         seen_rx = 0;
    int         seen_underrun = 0;
    int         seen_abort = 0;
    bit         mdl_buf_full = 0;
    logic [7:0] mdl_buf_word = 8'h00;
    bit         mdl_expect_oe = 0;
    int         ss_stable = 0;
    logic       ss_last = 1'b1;
    logic       prev_rx_valid = 1'b0;
    logic       prev_abort = 1'b0;
    logic       prev_underrun = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Per-cycle comparison against the model, sampled 1 ns after each rising edge.
    always @(posedge clk) begin
        logic [7:0] e;
        #1;
        if (bus_if.rx_valid) begin
            seen_rx++;
            if (exp_rx.size() == 0) begin
                checkOutput("rx_valid_unexpected", 1, 0);
            end else begin
                e = exp_rx.pop_front();
                checkOutput("rx_data_model", bus_if.rx_data, e);
            end
        end
        if (bus_if.rx_abort) seen_abort++;
        if (bus_if.tx_underrun) seen_underrun++;
        checkOutput("pulse_width",
                    {29'd0, bus_if.rx_valid & prev_rx_valid, bus_if.rx_abort & prev_abort,
                     bus_if.tx_underrun & prev_underrun}, 0);
        if (bus_if.SS !== ss_last) ss_stable = 0;
        else ss_stable++;
        if (ss_stable >= 4) begin
            checkOutput("miso_oe_model", bus_if.MISO_oe, mdl_expect_oe);
            checkOutput("busy_model", bus_if.busy, mdl_expect_oe);
        end
        ss_last       = bus_if.SS;
        prev_rx_valid = bus_if.rx_valid;
        prev_abort    = bus_if.rx_abort;
        prev_underrun = bus_if.tx_underrun;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic modelLoad(input bit bypass, input logic [7:0] bw, output logic [7:0] w);
        if (mdl_buf_full) begin
            w = mdl_buf_word;
            mdl_buf_full = 0;
        end else if (bypass) begin
            w = bw;
        end else begin
            w = IDLE_WORD;
            exp_underrun++;
        end
    endtask

    task automatic writeTx(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus_if.tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) checkOutput("tx_ready_timeout", 0, 1);
        bus_if.tx_data  = d;
        bus_if.tx_valid = 1'b1;
        @(negedge clk);
        bus_if.tx_valid = 1'b0;
        mdl_buf_full = 1;
        mdl_buf_word = d;
        checkOutput("tx_ready_drop", bus_if.tx_ready, 0);
    endtask

    // SS falls; the load lands on the third clk edge, so a bypass word is offered only around it.
    task automatic startFrame(input bit bypass, input logic [7:0] bw, output logic [7:0] w);
        bit was_full;
        @(negedge clk);
        was_full = mdl_buf_full;
        bus_if.SS = 1'b0;
        mdl_expect_oe = 1;
        modelLoad(bypass, bw, w);
        repeat (2) @(negedge clk);
        checkOutput("ready_before_load", bus_if.tx_ready, !was_full);
        checkOutput("oe_before_load", bus_if.MISO_oe, 0);
        if (bypass) begin
            bus_if.tx_data  = bw;
            bus_if.tx_valid = 1'b1;
        end
        @(negedge clk);
        bus_if.tx_valid = 1'b0;
        checkOutput("ready_after_load", bus_if.tx_ready, 1);
        checkOutput("oe_after_load", bus_if.MISO_oe, 1);
        checkOutput("first_miso_bit", bus_if.MISO, w[7]);
    endtask

    task automatic sclkBit(input logic mosi_bit, input bit end_frame, output logic miso_bit);
        bus_if.MOSI = mosi_bit;
        repeat (4) @(negedge clk);
        miso_bit = bus_if.MISO;
        bus_if.SCLK = 1'b1;
        repeat (4) @(negedge clk);
        bus_if.SCLK = 1'b0;
        if (end_frame) begin
            bus_if.SS = 1'b1;
            mdl_expect_oe = 0;
        end
    endtask

    task automatic spiWord(input logic [7:0] mosi_word, input int nbits, input bit end_frame,
                           output logic [7:0] cap);
        logic b;
        cap = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (i == 7) exp_rx.push_back(mosi_word);
            sclkBit(mosi_word[7-i], end_frame && (i == nbits - 1), b);
            cap = {cap[6:0], b};
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        mdl_buf_full  = 0;
        mdl_expect_oe = 0;
        repeat (2) @(negedge clk);
        checkOutput("reset_flags",
                    {bus_if.MISO, bus_if.MISO_oe, bus_if.rx_valid, bus_if.rx_abort,
                     bus_if.tx_underrun, bus_if.busy, bus_if.tx_ready}, 7'b0000001);
        checkOutput("reset_rx_data", bus_if.rx_data, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic applyStimulus(input int test_id);
        logic [7:0] w1, w2, c1, c2;
        logic       b;
        int         rx0, un0, ab0;
        rx0 = seen_rx;
        un0 = seen_underrun;
        ab0 = seen_abort;
        case (test_id)
            1: begin
                writeTx(8'hA5);
                startFrame(0, 8'h00, w1);
                checkOutput("t1_model_word", w1, 8'hA5);
                spiWord(8'h3C, 8, 1, c1);
                repeat (6) @(negedge clk);
                checkOutput("t1_miso_word", c1, w1);
                checkOutput("t1_rx_data", bus_if.rx_data, 8'h3C);
                checkOutput("t1_rx_pulses", seen_rx - rx0, 1);
                checkOutput("t1_underruns", seen_underrun - un0, 0);
            end
            2: begin
                startFrame(0, 8'h00, w1);
                checkOutput("t2_model_word", w1, 8'hFF);
                spiWord(8'h81, 8, 1, c1);
                repeat (6) @(negedge clk);
                checkOutput("t2_miso_word", c1, w1);
                checkOutput("t2_rx_data", bus_if.rx_data, 8'h81);
                checkOutput("t2_underruns", seen_underrun - un0, 1);
            end
            3: begin
                writeTx(8'h12);
                startFrame(0, 8'h00, w1);
                writeTx(8'h34);
                spiWord(8'hDE, 8, 0, c1);
                modelLoad(0, 8'h00, w2);
                spiWord(8'hAD, 8, 1, c2);
                repeat (6) @(negedge clk);
                checkOutput("t3_model_words", {w1, w2}, 16'h1234);
                checkOutput("t3_miso_word0", c1, w1);
                checkOutput("t3_miso_word1", c2, w2);
                checkOutput("t3_rx_pulses", seen_rx - rx0, 2);
                checkOutput("t3_rx_data", bus_if.rx_data, 8'hAD);
                checkOutput("t3_underruns", seen_underrun - un0, 0);
            end
            4: begin
                startFrame(0, 8'h00, w1);
                spiWord(8'hB7, 5, 1, c1);
                exp_abort++;
                repeat (6) @(negedge clk);
                checkOutput("t4_aborts", seen_abort - ab0, 1);
                checkOutput("t4_rx_pulses", seen_rx - rx0, 0);
                checkOutput("t4_miso_oe", bus_if.MISO_oe, 0);
                startFrame(0, 8'h00, w1);
                spiWord(8'h55, 8, 1, c1);
                repeat (6) @(negedge clk);
                checkOutput("t4_rx_data", bus_if.rx_data, 8'h55);
                checkOutput("t4_rx_pulses_after", seen_rx - rx0, 1);
            end
            5: begin
                startFrame(0, 8'h00, w1);
                spiWord(8'hF0, 3, 0, c1);
                doReset();
                for (int i = 3; i < 8; i++) sclkBit(1'b1, i == 7, b);
                repeat (6) @(negedge clk);
                checkOutput("t5_rx_pulses", seen_rx - rx0, 0);
                checkOutput("t5_aborts", seen_abort - ab0, 0);
                checkOutput("t5_miso_oe", bus_if.MISO_oe, 0);
                writeTx(8'h9A);
                startFrame(0, 8'h00, w1);
                spiWord(8'h66, 8, 1, c1);
                repeat (6) @(negedge clk);
                checkOutput("t5_miso_word", c1, 8'h9A);
                checkOutput("t5_rx_data", bus_if.rx_data, 8'h66);
            end
            6: begin
                startFrame(1, 8'hC3, w1);
                spiWord(8'h5A, 8, 1, c1);
                repeat (6) @(negedge clk);
                checkOutput("t6_miso_word", c1, 8'hC3);
                checkOutput("t6_underruns", seen_underrun - un0, 0);
                checkOutput("t6_tx_ready", bus_if.tx_ready, 1);
                checkOutput("t6_rx_data", bus_if.rx_data, 8'h5A);
            end
            default: ;
        endcase
    endtask

    initial begin
        rst             = 1'b1;
        bus_if.SS       = 1'b1;
        bus_if.SCLK     = 1'b0;
        bus_if.MOSI     = 1'b0;
        bus_if.tx_valid = 1'b0;
        bus_if.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("init_flags",
                    {bus_if.MISO, bus_if.MISO_oe, bus_if.rx_valid, bus_if.rx_abort,
                     bus_if.tx_underrun, bus_if.busy, bus_if.tx_ready}, 7'b0000001);
        checkOutput("init_rx_data", bus_if.rx_data, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int t = 1; t <= 6; t++) begin
            $display("[TB] running test %0d", t);
            applyStimulus(t);
        end

        checkOutput("rx_queue_drained", exp_rx.size(), 0);
        checkOutput("underrun_total", seen_underrun, exp_underrun);
        checkOutput("abort_total", seen_abort, exp_abort);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
